// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl
// Purpose  : PS/2 keyboard cursor and select control for a BOARD_W x BOARD_H
//            grid. Typematic repeats are filtered out by a make/break tracker.
// Macro    : CURSOR_CTRL_WRAP_EN makes the cursor wrap at the board edges.
//            When it is undefined, the cursor saturates at the edges.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_ctrl #(
  parameter int BOARD_W = 8,
  parameter int BOARD_H = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [10:0] key_event,
  input  logic        game_over,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        is_pressed,
  output logic        moved
);

`ifdef CURSOR_CTRL_WRAP_EN
  localparam bit c_WRAP = 1'b1;
`else
  localparam bit c_WRAP = 1'b0;
`endif
  localparam logic [4:0] c_XMAX = 5'(BOARD_W - 1);
  localparam logic [4:0] c_YMAX = 5'(BOARD_H - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t      state_q;
  logic [8:0]  held_key_q;
  logic [3:0]  x_q, y_q;
  logic        moved_q, pressed_q;

  logic        w_valid, w_brk;
  logic [8:0]  w_key;
  logic        w_up, w_dn, w_lf, w_rt, w_sel, w_mapped;
  logic        w_accept, w_release, w_act;
  logic [4:0]  w_x5, w_y5;
  logic [4:0]  x_d, y_d;
  logic        moved_d, pressed_d;

  assign w_valid = key_event[10];
  assign w_brk   = key_event[8];
  assign w_key   = {key_event[9], key_event[7:0]};

  assign w_up  = (w_key == 9'h175) || (w_key == 9'h01D);
  assign w_dn  = (w_key == 9'h172) || (w_key == 9'h01B);
  assign w_lf  = (w_key == 9'h16B) || (w_key == 9'h01C);
  assign w_rt  = (w_key == 9'h174) || (w_key == 9'h023);
  assign w_sel = (w_key == 9'h05A) || (w_key == 9'h029);
  assign w_mapped = w_up | w_dn | w_lf | w_rt | w_sel;

  // A make equal to the held key is a typematic repeat unless the tracker is idle.
  assign w_accept  = w_valid && !w_brk && w_mapped &&
                     ((state_q == IDLE) || (w_key != held_key_q));
  assign w_release = w_valid && w_brk && (state_q == HELD) && (w_key == held_key_q);
  assign w_act     = w_accept && !game_over;

  assign w_x5 = {1'b0, x_q};
  assign w_y5 = {1'b0, y_q};

  always_comb begin
    x_d = w_x5;
    y_d = w_y5;
    if (w_lf) begin
      if (w_x5 == 5'd0) x_d = c_WRAP ? c_XMAX : w_x5;
      else              x_d = w_x5 - 5'd1;
    end else if (w_rt) begin
      if (w_x5 == c_XMAX) x_d = c_WRAP ? 5'd0 : w_x5;
      else                x_d = w_x5 + 5'd1;
    end else if (w_up) begin
      if (w_y5 == 5'd0) y_d = c_WRAP ? c_YMAX : w_y5;
      else              y_d = w_y5 - 5'd1;
    end else if (w_dn) begin
      if (w_y5 == c_YMAX) y_d = c_WRAP ? 5'd0 : w_y5;
      else                y_d = w_y5 + 5'd1;
    end
  end

  assign moved_d   = w_act && ((x_d != w_x5) || (y_d != w_y5));
  assign pressed_d = w_act && w_sel;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      held_key_q <= 9'd0;
      x_q        <= 4'd0;
      y_q        <= 4'd0;
      moved_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      // The hold tracker keeps running while game_over freezes the cursor.
      if (w_accept) begin
        state_q    <= HELD;
        held_key_q <= w_key;
      end else if (w_release) begin
        state_q    <= IDLE;
      end
      if (w_act) begin
        x_q <= x_d[3:0];
        y_q <= y_d[3:0];
      end
      moved_q   <= moved_d;
      pressed_q <= pressed_d;
    end
  end

  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign is_pressed = pressed_q;
  assign moved      = moved_q;

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_ctrl
// Purpose  : Directed self-checking bench for cursor_ctrl (8x8 board).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_ctrl;

  logic        clk;
  logic        rstn;
  logic [10:0] key_event;
  logic        game_over;
  logic [3:0]  cursor_x, cursor_y;
  logic        is_pressed, moved;

  int n_vec;
  int n_err;

  cursor_ctrl #(.BOARD_W(8), .BOARD_H(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_event  (key_event),
    .game_over  (game_over),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .is_pressed (is_pressed),
    .moved      (moved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic ext, input logic [7:0] code);
    return {1'b1, ext, 1'b0, code};
  endfunction

  function automatic logic [10:0] brk(input logic ext, input logic [7:0] code);
    return {1'b1, ext, 1'b1, code};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one event for one clock; return 1 time unit after the edge.
  task automatic step(input logic [10:0] ev);
    key_event = ev;
    @(posedge clk);
    #1;
    key_event = 11'd0;
  endtask

  task automatic pos(input string tag, input int ex, input int ey, input logic em);
    chk({tag, ".x"}, {4'd0, cursor_x}, 8'(ex));
    chk({tag, ".y"}, {4'd0, cursor_y}, 8'(ey));
    chk({tag, ".moved"}, {7'd0, moved}, {7'd0, em});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    key_event = 11'd0;
    game_over = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pos("rst", 0, 0, 1'b0);
    chk("rst.press", {7'd0, is_pressed}, 8'd0);
    rstn = 1'b1;

    // Basic right move, latency 1, single-cycle moved pulse
    step(mk(1'b0, 8'h23));   pos("right", 1, 0, 1'b1);
    step(11'd0);             pos("right.idle", 1, 0, 1'b0);

    // Typematic repeat filtering on extended down
    step(mk(1'b1, 8'h72));   pos("down1", 1, 1, 1'b1);
    step(mk(1'b1, 8'h72));   pos("down.rep1", 1, 1, 1'b0);
    step(mk(1'b1, 8'h72));   pos("down.rep2", 1, 1, 1'b0);
    step(brk(1'b1, 8'h72));  pos("down.brk", 1, 1, 1'b0);
    step(mk(1'b1, 8'h72));   pos("down2", 1, 2, 1'b1);

    // Left edge at x=0
    step(mk(1'b0, 8'h1C));   pos("left1", 0, 2, 1'b1);
    step(brk(1'b0, 8'h1C));  pos("left.brk", 0, 2, 1'b0);
    step(mk(1'b0, 8'h1C));
`ifdef CURSOR_CTRL_WRAP_EN
    pos("left.edge", 7, 2, 1'b1);
    step(brk(1'b0, 8'h1C));
    step(mk(1'b0, 8'h23));   pos("right.wrap", 0, 2, 1'b1);
    step(brk(1'b0, 8'h23));
`else
    pos("left.edge", 0, 2, 1'b0);
    step(brk(1'b0, 8'h1C));
`endif

    // Select pulses
    step(mk(1'b0, 8'h5A));
    chk("sel.enter", {7'd0, is_pressed}, 8'd1);
    chk("sel.nomove", {7'd0, moved}, 8'd0);
    step(11'd0);             chk("sel.1cyc", {7'd0, is_pressed}, 8'd0);
    step(mk(1'b0, 8'h5A));   chk("sel.rep", {7'd0, is_pressed}, 8'd0);
    step(mk(1'b0, 8'h29));   chk("sel.space", {7'd0, is_pressed}, 8'd1);
    step(11'd0);             chk("sel.space.1cyc", {7'd0, is_pressed}, 8'd0);
    step(brk(1'b0, 8'h29));

    // Unmapped codes change neither outputs nor hold state
    step(mk(1'b1, 8'h23));   pos("unmap.e0_23", 0, 2, 1'b0);
    step(mk(1'b0, 8'h29));   chk("hold.sel", {7'd0, is_pressed}, 8'd1);
    step(mk(1'b1, 8'h11));   chk("unmap.e0_11", {7'd0, is_pressed}, 8'd0);
    step(mk(1'b0, 8'h29));   chk("hold.kept", {7'd0, is_pressed}, 8'd0);
    step(brk(1'b0, 8'h29));

    // game_over rising with the event: only the tracker updates
    game_over = 1'b1;
    step(mk(1'b0, 8'h23));   pos("gover", 0, 2, 1'b0);
    game_over = 1'b0;
    step(mk(1'b0, 8'h23));   pos("gover.held", 0, 2, 1'b0);
    step(brk(1'b0, 8'h23));
    step(mk(1'b0, 8'h23));   pos("gover.after", 1, 2, 1'b1);

    // Back-to-back strobes
    step(mk(1'b0, 8'h1B));   pos("b2b.down", 1, 3, 1'b1);
    step(mk(1'b0, 8'h23));   pos("b2b.right", 2, 3, 1'b1);
    step(brk(1'b0, 8'h23));
    step(mk(1'b0, 8'h23));   pos("to34.x", 3, 3, 1'b1);
    step(mk(1'b0, 8'h1B));   pos("to34.y", 3, 4, 1'b1);
    step(brk(1'b0, 8'h1B));

    // Reset overrides a coincident make
    rstn = 1'b0;
    step(mk(1'b0, 8'h1B));   pos("rst.coinc", 0, 0, 1'b0);
    chk("rst.coinc.press", {7'd0, is_pressed}, 8'd0);
    rstn = 1'b1;
    step(11'd0);             pos("rst.after", 0, 0, 1'b0);
    step(mk(1'b0, 8'h1B));   pos("rst.first", 0, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
